// File: rtl/sample_averager_pkg.sv
// Shared types and helpers for the triggered coherent sample averager.
// Holds the FSM state encoding, the pass-counter width and the sample sign-extension function.
package sample_averager_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    ACCUM     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int CNT_WIDTH = 16;

  // Sign-extends the low 'bits' bits of data to 64 bits; callers truncate to their width.
  function automatic logic signed [63:0] sign_extend(input logic [63:0] data,
                                                     input int unsigned bits);
    logic [63:0] tmp;
    tmp = data << (64 - bits);
    return $signed(tmp) >>> (64 - bits);
  endfunction

endpackage

// File: rtl/averager_ram.sv
// Simple dual-port accumulator memory: one write port, one registered read port.
// Contents are not reset; a read of an address being written returns the old word.
module averager_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_averager.sv
// Triggered coherent averager: accumulates a window of samples per trigger edge into RAM.
// Optional SAMPLE_AVERAGER_DOWNSHIFT_EN applies an arithmetic right shift on readout.
//
// state     | meaning
// IDLE      | waiting for start after reset
// WAIT_TRIG | armed, waiting for a trigger rising edge
// ACCUM     | accumulating the window; fin_q marks the final-write retire cycle
// DONE      | all passes complete, sums readable
module sample_averager
  import sample_averager_pkg::*;
#(
  parameter int ADC_DATA_WIDTH   = 16,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ADDR_WIDTH       = 10,
  parameter int ACC_WIDTH        = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        trig,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       cfg_nsamples,
  input  logic [CNT_WIDTH-1:0]        cfg_navg,
  input  logic [4:0]                  cfg_shift,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_WIDTH-1:0]        avg_count,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [ACC_WIDTH-1:0]        rd_data
);

  state_t state_q, state_d;

  logic                  trig_q, trig_edge;
  logic [ADDR_WIDTH-1:0] nsamples_q, idx_q;
  logic [CNT_WIDTH-1:0]  navg_q, avg_count_q;
  logic                  fin_q, fin_last_q;
  logic                  beat, beat_last, start_ok;
  logic                  wr_en_q, wr_first_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, ram_raddr;
  logic [ACC_WIDTH-1:0]  wr_sample_q, wr_data, ram_q, sample_ext, rd_val;
  logic                  rd_ok_q;

  assign s_axis_tready = 1'b1;
  assign busy          = (state_q == WAIT_TRIG) || (state_q == ACCUM);
  assign done          = (state_q == DONE);
  assign avg_count     = avg_count_q;

  assign trig_edge  = trig & ~trig_q;
  assign start_ok   = start & ((state_q == IDLE) || (state_q == DONE));
  // The edge cycle itself may carry sample 0.
  assign beat       = s_axis_tvalid & (((state_q == ACCUM) & ~fin_q) |
                                       ((state_q == WAIT_TRIG) & trig_edge));
  assign beat_last  = beat & (idx_q == nsamples_q);
  assign sample_ext = ACC_WIDTH'(sign_extend(64'(s_axis_tdata), ADC_DATA_WIDTH));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = WAIT_TRIG;
      WAIT_TRIG:  if (trig_edge) state_d = ACCUM;
      ACCUM:      if (fin_q) state_d = fin_last_q ? DONE : WAIT_TRIG;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      trig_q      <= 1'b0;
      nsamples_q  <= '0;
      navg_q      <= '0;
      idx_q       <= '0;
      avg_count_q <= '0;
      fin_q       <= 1'b0;
      fin_last_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_first_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_sample_q <= '0;
      rd_ok_q     <= 1'b0;
    end else begin
      trig_q      <= trig;
      wr_en_q     <= beat;
      wr_addr_q   <= idx_q;
      wr_sample_q <= sample_ext;
      wr_first_q  <= (avg_count_q == '0);
      fin_q       <= beat_last;
      rd_ok_q     <= ~busy;
      if (beat) idx_q <= beat_last ? '0 : idx_q + 1'b1;
      if (beat_last) begin
        fin_last_q  <= (avg_count_q == navg_q);
        avg_count_q <= avg_count_q + 1'b1;
      end
      if (start_ok) begin
        nsamples_q  <= cfg_nsamples;
        navg_q      <= cfg_navg;
        avg_count_q <= '0;
        idx_q       <= '0;
      end
    end
  end

  // Pass 0 overwrites, so stale RAM never needs a clear pass.
  assign wr_data   = wr_first_q ? wr_sample_q : ram_q + wr_sample_q;
  assign ram_raddr = busy ? idx_q : rd_addr;

  averager_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(ACC_WIDTH)
  ) u_ram (
    .clk  (aclk),
    .we   (wr_en_q),
    .waddr(wr_addr_q),
    .wdata(wr_data),
    .raddr(ram_raddr),
    .rdata(ram_q)
  );

`ifdef SAMPLE_AVERAGER_DOWNSHIFT_EN
  logic [4:0] shift_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) shift_q <= '0;
    else        shift_q <= cfg_shift;
  end

  assign rd_val = $signed(ram_q) >>> shift_q;
`else
  logic unused_cfg_shift;
  assign unused_cfg_shift = ^cfg_shift;
  assign rd_val = ram_q;
`endif

  assign rd_data = (rd_ok_q && !busy) ? rd_val : '0;

endmodule

// File: doc/sample_averager.md
# sample_averager

Triggered, coherent signal averager placed directly downstream of the channel splitter that produces a sign-extended 32-bit stream per ADC channel. On each trigger rising edge it captures a window of consecutive samples and accumulates it, point by point, into an internal memory. After the configured number of triggers it stops, flags completion, and exposes the sums through a synchronous read port for the PS-side readout logic.

## Interface
- ADC_DATA_WIDTH, 16, significant sample bits in the low part of s_axis_tdata
- AXIS_TDATA_WIDTH, 32, input stream width
- ADDR_WIDTH, 10, log2 of accumulator depth (max window 1024 points)
- ACC_WIDTH, 32, accumulator word width
- aclk  in  1  sole clock
- areset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  AXIS_TDATA_WIDTH  sign-extended sample
- s_axis_tvalid  in  1  sample beat qualifier
- s_axis_tready  out  1  constant 1; the block never stalls
- trig  in  1  level trigger; rising edge starts a pass
- start  in  1  single-cycle run request
- cfg_nsamples  in  ADDR_WIDTH  window length minus 1
- cfg_navg  in  16  number of passes minus 1
- cfg_shift  in  5  readout right-shift (used only under SAMPLE_AVERAGER_DOWNSHIFT_EN)
- busy  out  1  high from accepted start until DONE
- done  out  1  level, high in DONE
- avg_count  out  16  completed passes
- rd_addr  in  ADDR_WIDTH  readout address
- rd_data  out  ACC_WIDTH  readout data

## Operation
- States: IDLE, WAIT_TRIG, ACCUM, DONE. Reset to IDLE; busy=0, done=0, avg_count=0, rd_data=0, trig history=0. RAM contents are not reset.
- IDLE/DONE + start: latch cfg_nsamples/cfg_navg, clear avg_count and sample index, go to WAIT_TRIG. In WAIT_TRIG/ACCUM, start is ignored.
- WAIT_TRIG: the rising edge (trig=1, previous trig=0) arms the pass. Sample 0 is the first valid beat at or after the edge cycle, including the edge cycle itself. Edges outside WAIT_TRIG are ignored, with no queuing.
- ACCUM: each valid beat at index i does sample = sign-extend(s_axis_tdata[ADC_DATA_WIDTH-1:0]) to ACC_WIDTH.
  - Pass 0: mem[i] = sample, so no clear pass is needed.
  - Later passes: mem[i] = mem[i] + sample, with two's-complement wrap and no saturation. Choosing ACC_WIDTH ≥ ADC_DATA_WIDTH + log2(passes) is the integrator's responsibility.
- Beats with tvalid=0 do not advance the index.
- After the beat at i = latched nsamples, avg_count increments. The block then goes to DONE if avg_count had equalled latched navg, otherwise to WAIT_TRIG. Both transitions take effect only once the final write has retired.
- Readout: while busy, rd_data=0. Otherwise rd_data = mem[rd_addr] at 1-cycle latency.
- areset mid-pass: the block returns to IDLE immediately and the memory holds partial sums, which are undefined for use.

## Timing
- Beat at cycle t: RAM read of mem[i] is issued at t. The sum is formed and the write is issued at t+1.
- Consecutive beats hit distinct addresses, so no hazard arises. The next pass cannot begin before the final write retires, so nsamples=0 (window length 1) is hazard-free.
- Last beat of the last pass at t: done=1 and busy=0 from t+2.
- Last beat of a non-final pass at t: WAIT_TRIG from t+2. An edge seen at t+2 is accepted.
- Throughput: one sample per cycle, sustained.

## Configuration
- SAMPLE_AVERAGER_DOWNSHIFT_EN defined: rd_data = mem[rd_addr] >>> cfg_shift (arithmetic). cfg_shift is sampled with rd_addr, and the latency is unchanged.
- Undefined: rd_data is the raw sum and cfg_shift is ignored. The port list stays identical either way.

## Structure
- Package sample_averager_pkg holds the state enum, the 16-bit pass-count width constant, and the sign-extension helper function.
- Sub-module averager_ram: simple dual-port RAM with 1 write and 1 synchronous read port, depth 2^ADDR_WIDTH, width ACC_WIDTH. The read-address mux (accumulation vs rd_addr, selected by busy) stays in the top module.

## Test plan
- Window 4, 1 pass (cfg_nsamples=3, cfg_navg=0); samples 1,2,-3,0x7FFF after the edge -> mem = 1, 2, -3 (0xFFFFFFFD), 32767; done at last beat + 2.
- Window 4, 3 passes of constant -5 -> every mem entry equals -15; avg_count=3.
- tvalid gaps every other cycle and trig edges during ACCUM -> the same sums as gap-free stimulus; the extra edges are ignored.
- cfg_nsamples=0, 4 passes, with triggers at the minimum spacing (edge seen at t+2) -> mem[0] = sum of the 4 samples, with no lost edge or hazard.
- start during ACCUM, then areset mid-pass -> start is ignored; after reset the state is IDLE, busy=0, done=0, avg_count=0.
- With SAMPLE_AVERAGER_DOWNSHIFT_EN, mem[0]=-64 and cfg_shift=3 -> rd_data=-8 one cycle after rd_addr=0. Without the macro -> rd_data=-64.
